// File: rtl/axilite_regbank.sv
// AXI-Lite backend register bank: CTRL/STATUS/IRQ/SCRATCH/ID with fixed-latency reads.
// Optional write lock register at 0x018 enabled by AXILITE_REGBANK_WLOCK_EN.
module axilite_regbank #(
    parameter int unsigned RD_LAT   = 2,
    parameter logic [31:0] ID_VALUE = 32'h4653_4943
) (
    input  logic        axi_aclk,
    input  logic        axi_areset,
    input  logic        bk_wstart,
    input  logic [11:0] bk_waddr,
    input  logic [31:0] bk_wdata,
    input  logic [3:0]  bk_wstrb,
    input  logic        bk_rstart,
    input  logic [11:0] bk_raddr,
    output logic [31:0] bk_rdata,
    output logic        bk_rdone,
    output logic [31:0] cfg_ctrl,
    input  logic [31:0] sts_in,
    input  logic [7:0]  irq_event,
    output logic        irq
);

    localparam logic [9:0] AddrCtrl    = 10'h000;
    localparam logic [9:0] AddrStatus  = 10'h001;
    localparam logic [9:0] AddrIrqStat = 10'h002;
    localparam logic [9:0] AddrIrqEn   = 10'h003;
    localparam logic [9:0] AddrScratch = 10'h004;
    localparam logic [9:0] AddrId      = 10'h005;
    localparam logic [9:0] AddrLock    = 10'h006;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] status_q;
    logic [7:0]  irq_stat_q, irq_stat_d;
    logic [7:0]  irq_en_q, irq_en_d;
    logic [31:0] scratch_q, scratch_d;
    logic        irq_q;
    logic [9:0]  wr_word, rd_word;
    logic [7:0]  irq_clr;
    logic [31:0] rd_val;
    logic        wr_unlocked;
    logic        unused_addr_bits;

    assign wr_word          = bk_waddr[11:2];
    assign rd_word          = bk_raddr[11:2];
    assign unused_addr_bits = ^{bk_waddr[1:0], bk_raddr[1:0]};

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

`ifdef AXILITE_REGBANK_WLOCK_EN
    logic lock_q, lock_d;

    assign wr_unlocked = ~lock_q;
    // Sticky: a write can only set LOCK, reset is the only way out.
    assign lock_d = lock_q | (bk_wstart && wr_word == AddrLock && bk_wstrb[0] && bk_wdata[0]);

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) lock_q <= 1'b0;
        else            lock_q <= lock_d;
    end
`else
    assign wr_unlocked = 1'b1;
`endif

    always_comb begin
        ctrl_d    = ctrl_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        irq_clr   = '0;
        if (bk_wstart) begin
            unique case (wr_word)
                AddrCtrl:    if (wr_unlocked) ctrl_d = strb_merge(ctrl_q, bk_wdata, bk_wstrb);
                AddrIrqStat: if (bk_wstrb[0]) irq_clr = bk_wdata[7:0];
                AddrIrqEn:   if (wr_unlocked && bk_wstrb[0]) irq_en_d = bk_wdata[7:0];
                AddrScratch: scratch_d = strb_merge(scratch_q, bk_wdata, bk_wstrb);
                default: ;
            endcase
        end
        // Set wins over a simultaneous W1C.
        irq_stat_d = (irq_stat_q & ~irq_clr) | irq_event;
    end

    always_comb begin
        rd_val = '0;
        unique case (rd_word)
            AddrCtrl:    rd_val = ctrl_q;
            AddrStatus:  rd_val = status_q;
            AddrIrqStat: rd_val = {24'b0, irq_stat_q};
            AddrIrqEn:   rd_val = {24'b0, irq_en_q};
            AddrScratch: rd_val = scratch_q;
            AddrId:      rd_val = ID_VALUE;
`ifdef AXILITE_REGBANK_WLOCK_EN
            AddrLock:    rd_val = {31'b0, lock_q};
`endif
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            ctrl_q     <= '0;
            status_q   <= '0;
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            scratch_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            status_q   <= sts_in;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            scratch_q  <= scratch_d;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    // Read FSM: state register.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Read FSM: next state. A start while busy is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (bk_rstart) begin
                    state_d = StBusy;
                    cnt_d   = 4'(RD_LAT - 1);
                    hold_d  = rd_val;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) state_d = StIdle;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read FSM: outputs.
    always_comb begin
        bk_rdone = (state_q == StBusy) && (cnt_q == 4'd0);
        bk_rdata = bk_rdone ? hold_q : '0;
    end

    assign cfg_ctrl = ctrl_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_axilite_regbank.sv
// Self-checking bench for axilite_regbank: vector table plus directed corner-case sequences.
module tb_axilite_regbank;

    localparam int unsigned RdLat = 2;
    localparam logic [31:0] IdVal = 32'h4653_4943;

    logic        axi_aclk = 1'b0;
    logic        axi_areset;
    logic        bk_wstart = 1'b0;
    logic [11:0] bk_waddr = '0;
    logic [31:0] bk_wdata = '0;
    logic [3:0]  bk_wstrb = '0;
    logic        bk_rstart = 1'b0;
    logic [11:0] bk_raddr = '0;
    logic [31:0] bk_rdata;
    logic        bk_rdone;
    logic [31:0] cfg_ctrl;
    logic [31:0] sts_in = 32'h5A5A_0001;
    logic [7:0]  irq_event = '0;
    logic        irq;

    int n_total = 0;
    int n_pass  = 0;

    axilite_regbank #(.RD_LAT(RdLat), .ID_VALUE(IdVal)) dut (
        .axi_aclk  (axi_aclk),
        .axi_areset(axi_areset),
        .bk_wstart (bk_wstart),
        .bk_waddr  (bk_waddr),
        .bk_wdata  (bk_wdata),
        .bk_wstrb  (bk_wstrb),
        .bk_rstart (bk_rstart),
        .bk_raddr  (bk_raddr),
        .bk_rdata  (bk_rdata),
        .bk_rdone  (bk_rdone),
        .cfg_ctrl  (cfg_ctrl),
        .sts_in    (sts_in),
        .irq_event (irq_event),
        .irq       (irq)
    );

    always #5 axi_aclk = ~axi_aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, got, exp);
    endtask

    // Starts at a negedge, ends at a negedge.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        bk_wstart = 1'b1;
        bk_waddr  = a;
        bk_wdata  = d;
        bk_wstrb  = s;
        @(negedge axi_aclk);
        bk_wstart = 1'b0;
    endtask

    // Observe n cycles; lat is the first cycle (1-based) with rdone high.
    task automatic watch(input int n, output int ndone, output int lat, output logic [31:0] d,
                         output int bad_idle);
        ndone = 0; lat = -1; d = '0; bad_idle = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge axi_aclk);
            bk_rstart = 1'b0;
            bk_wstart = 1'b0;
            if (bk_rdone) begin
                ndone++;
                if (lat < 0) begin
                    lat = i;
                    d   = bk_rdata;
                end
            end else if (bk_rdata !== 32'h0) begin
                bad_idle++;
            end
        end
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        int ndone, lat, bad;
        logic [31:0] d;
        bk_rstart = 1'b1;
        bk_raddr  = a;
        watch(6, ndone, lat, d, bad);
        check({name, " data"}, d, exp);
        check({name, " lat"}, 32'(lat), RdLat);
        check({name, " ndone"}, 32'(ndone), 32'd1);
        check({name, " idle rdata"}, 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;   // read: rdata; write: cfg_ctrl afterwards
        string       name;
    } vec_t;

    vec_t vq[$];

    initial begin
        int ndone, lat, bad;
        logic [31:0] d;

        vq.push_back('{1'b0, 12'h014, 32'h0, 4'h0, IdVal,        "rd id"});
        vq.push_back('{1'b0, 12'h000, 32'h0, 4'h0, 32'h0,        "rd ctrl rst"});
        vq.push_back('{1'b0, 12'h004, 32'h0, 4'h0, 32'h5A5A0001, "rd status"});
        vq.push_back('{1'b0, 12'h008, 32'h0, 4'h0, 32'h0,        "rd irqstat rst"});
        vq.push_back('{1'b0, 12'h00C, 32'h0, 4'h0, 32'h0,        "rd irqen rst"});
        vq.push_back('{1'b0, 12'h010, 32'h0, 4'h0, 32'h0,        "rd scratch rst"});
        vq.push_back('{1'b1, 12'h010, 32'hAABBCCDD, 4'b0101, 32'h0, "wr scratch strb"});
        vq.push_back('{1'b0, 12'h010, 32'h0, 4'h0, 32'h00BB00DD, "rd scratch strb"});
        vq.push_back('{1'b1, 12'h000, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, "wr ctrl full"});
        vq.push_back('{1'b1, 12'h000, 32'h11223344, 4'b1000, 32'h11FEF00D, "wr ctrl b3"});
        vq.push_back('{1'b0, 12'h000, 32'h0, 4'h0, 32'h11FEF00D, "rd ctrl"});
        vq.push_back('{1'b1, 12'h00C, 32'hFFFFFFFF, 4'b1110, 32'h11FEF00D, "wr irqen no b0"});
        vq.push_back('{1'b0, 12'h00C, 32'h0, 4'h0, 32'h0,        "rd irqen no b0"});
        vq.push_back('{1'b1, 12'h00C, 32'h123456A5, 4'hF, 32'h11FEF00D, "wr irqen"});
        vq.push_back('{1'b0, 12'h00F, 32'h0, 4'h0, 32'h000000A5, "rd irqen lowbits"});
        vq.push_back('{1'b1, 12'h014, 32'h0, 4'hF, 32'h11FEF00D, "wr id ro"});
        vq.push_back('{1'b0, 12'h014, 32'h0, 4'h0, IdVal,        "rd id after wr"});
        vq.push_back('{1'b1, 12'h020, 32'hDEADBEEF, 4'hF, 32'h11FEF00D, "wr unmapped"});
        vq.push_back('{1'b0, 12'h020, 32'h0, 4'h0, 32'h0,        "rd unmapped"});
        vq.push_back('{1'b0, 12'hFFC, 32'h0, 4'h0, 32'h0,        "rd top"});

        axi_areset = 1'b1;
        repeat (3) @(negedge axi_aclk);
        check("rst rdata", bk_rdata, 32'h0);
        check("rst rdone", {31'b0, bk_rdone}, 32'h0);
        check("rst cfg_ctrl", cfg_ctrl, 32'h0);
        check("rst irq", {31'b0, irq}, 32'h0);
        axi_areset = 1'b0;
        @(negedge axi_aclk);

        foreach (vq[i]) begin
            if (vq[i].wr) begin
                do_write(vq[i].addr, vq[i].data, vq[i].strb);
                check(vq[i].name, cfg_ctrl, vq[i].exp);
            end else begin
                read_check(vq[i].name, vq[i].addr, vq[i].exp);
            end
        end

        // STATUS returns sts_in from the edge before the read strobe.
        sts_in = 32'h1111_1111;
        @(negedge axi_aclk);
        sts_in = 32'h2222_2222;
        read_check("rd status pre", 12'h004, 32'h1111_1111);

        // Interrupt masking, latency, set-beats-clear, clear.
        do_write(12'h00C, 32'h04, 4'h1);
        irq_event = 8'h02;
        @(negedge axi_aclk);
        irq_event = 8'h00;
        repeat (2) @(negedge axi_aclk);
        check("irq masked", {31'b0, irq}, 32'h0);
        read_check("rd irqstat masked", 12'h008, 32'h02);
        do_write(12'h008, 32'h02, 4'h1);
        read_check("rd irqstat w1c", 12'h008, 32'h0);
        irq_event = 8'h04;
        @(negedge axi_aclk);
        irq_event = 8'h00;
        check("irq 1 cyc", {31'b0, irq}, 32'h0);
        @(negedge axi_aclk);
        check("irq 2 cyc", {31'b0, irq}, 32'h1);
        irq_event = 8'h04;
        do_write(12'h008, 32'h04, 4'h1);
        irq_event = 8'h00;
        read_check("rd irqstat set wins", 12'h008, 32'h04);
        check("irq held", {31'b0, irq}, 32'h1);
        do_write(12'h008, 32'h04, 4'h1);
        @(negedge axi_aclk);
        check("irq cleared", {31'b0, irq}, 32'h0);

        // Write and read of CTRL in the same cycle: read sees the old value.
        do_write(12'h000, 32'h0, 4'hF);
        bk_wstart = 1'b1; bk_waddr = 12'h000; bk_wdata = 32'h1234; bk_wstrb = 4'hF;
        bk_rstart = 1'b1; bk_raddr = 12'h000;
        @(negedge axi_aclk);
        bk_wstart = 1'b0; bk_rstart = 1'b0;
        check("ctrl same cyc", cfg_ctrl, 32'h1234);
        check("rdone early", {31'b0, bk_rdone}, 32'h0);
        watch(6, ndone, lat, d, bad);
        check("rd ctrl old", d, 32'h0);
        check("rd ctrl old lat", 32'(lat), RdLat - 1);
        check("rd ctrl old ndone", 32'(ndone), 32'd1);

        // Second start while busy is dropped.
        bk_rstart = 1'b1; bk_raddr = 12'h014;
        @(negedge axi_aclk);
        bk_raddr = 12'h010;
        watch(8, ndone, lat, d, bad);
        check("dbl ndone", 32'(ndone), 32'd1);
        check("dbl data", d, IdVal);
        check("dbl lat", 32'(lat), RdLat - 1);
        check("dbl idle rdata", 32'(bad), 32'd0);

        // Reset in the middle of a read aborts it and clears state.
        do_write(12'h010, 32'h5555_AAAA, 4'hF);
        irq_event = 8'h04;
        @(negedge axi_aclk);
        irq_event = 8'h00;
        repeat (2) @(negedge axi_aclk);
        check("irq pre-rst", {31'b0, irq}, 32'h1);
        bk_rstart = 1'b1; bk_raddr = 12'h014;
        @(negedge axi_aclk);
        bk_rstart = 1'b0;
        axi_areset = 1'b1;
        #1;
        check("midrst rdone", {31'b0, bk_rdone}, 32'h0);
        check("midrst rdata", bk_rdata, 32'h0);
        check("midrst cfg_ctrl", cfg_ctrl, 32'h0);
        check("midrst irq", {31'b0, irq}, 32'h0);
        @(negedge axi_aclk);
        axi_areset = 1'b0;
        watch(6, ndone, lat, d, bad);
        check("midrst no rdone", 32'(ndone), 32'd0);
        read_check("rd scratch post-rst", 12'h010, 32'h0);
        read_check("rd irqen post-rst", 12'h00C, 32'h0);

`ifdef AXILITE_REGBANK_WLOCK_EN
        do_write(12'h018, 32'h1, 4'h1);
        do_write(12'h000, 32'hFFFF_FFFF, 4'hF);
        check("lock ctrl", cfg_ctrl, 32'h0);
        do_write(12'h018, 32'h0, 4'hF);
        read_check("rd lock sticky", 12'h018, 32'h1);
        do_write(12'h00C, 32'hFF, 4'hF);
        read_check("rd irqen locked", 12'h00C, 32'h0);
        do_write(12'h010, 32'h1234_5678, 4'hF);
        read_check("rd scratch locked", 12'h010, 32'h1234_5678);
`else
        do_write(12'h018, 32'hFFFF_FFFF, 4'hF);
        read_check("rd 0x018 unmapped", 12'h018, 32'h0);
        do_write(12'h000, 32'h55, 4'hF);
        check("ctrl unlocked", cfg_ctrl, 32'h55);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axilite_regbank.md
# axilite_regbank

Register bank that consumes the backend write/read interface of the AXI-Lite slave front end. It holds the block's control, interrupt and scratch registers, and samples status. Each `bk_rstart` produces exactly one `bk_rdone` pulse after a programmable latency. It sits directly behind the AXI-Lite slave and drives configuration outputs and an interrupt line into the user logic.

## Interface
Parameters:
- `RD_LAT`, default 2: cycles from `bk_rstart` to `bk_rdone`; legal range 1..15.
- `ID_VALUE`, default 32'h4653_4943: constant returned by the ID register.

Ports:
- `axi_aclk`  in  1  clock; all logic on the rising edge.
- `axi_areset`  in  1  asynchronous, active-high reset.
- `bk_wstart`  in  1  write strobe; one-cycle pulse.
- `bk_waddr`  in  12  byte address; bits [1:0] ignored.
- `bk_wdata`  in  32  write data.
- `bk_wstrb`  in  4  byte enables.
- `bk_rstart`  in  1  read strobe; one-cycle pulse.
- `bk_raddr`  in  12  byte address; bits [1:0] ignored.
- `bk_rdata`  out  32  read data; valid only while `bk_rdone` is 1, otherwise 0.
- `bk_rdone`  out  1  read completion; one-cycle pulse.
- `cfg_ctrl`  out  32  CTRL register contents.
- `sts_in`  in  32  status from user logic.
- `irq_event`  in  8  interrupt event pulses; level-sampled each cycle.
- `irq`  out  1  registered interrupt request.

## Operation
Register map (word-aligned):
- 0x000 CTRL: RW, reset 0.
- 0x004 STATUS: RO; value is `sts_in` registered one cycle.
- 0x008 IRQ_STAT[7:0]: W1C, reset 0.
- 0x00C IRQ_EN[7:0]: RW, reset 0.
- 0x010 SCRATCH: RW, reset 0.
- 0x014 ID: RO, returns `ID_VALUE`.
- All other addresses: reads return 0; writes are ignored.

Write behaviour:
- Writes complete in the `bk_wstart` cycle. Each byte `i` is updated only where `bk_wstrb[i]` is 1. Writes to RO registers are ignored.
- IRQ_STAT: each bit sets when its `irq_event` bit is 1. A bit clears on a write with `bk_wdata` bit = 1 and `bk_wstrb[0]` = 1. If set and clear hit the same bit in the same cycle, set wins.
- Bits [31:8] of IRQ_STAT and IRQ_EN read 0.

Read FSM:
- States: IDLE and BUSY.
- IDLE → BUSY on `bk_rstart`. On that edge the addressed register value is snapshotted into a read-data holding register and the latency counter is loaded with `RD_LAT-1`.
- BUSY decrements the counter. When the counter is 0, the block pulses `bk_rdone` with the snapshot on `bk_rdata` and returns to IDLE.
- The snapshot is the pre-edge value. A write in the same cycle as `bk_rstart` to the same address is not visible to that read.
- A `bk_rstart` while BUSY is dropped: no extra `bk_rdone`, and the pending read is unaffected.

Interrupt:
- `irq` <= |(IRQ_STAT & IRQ_EN), registered.

## Timing
- Reset values: `bk_rdata`=0, `bk_rdone`=0, `cfg_ctrl`=0, `irq`=0. The FSM resets to IDLE and the counter to 0.
- `bk_rdone` is asserted exactly `RD_LAT` cycles after the `bk_rstart` cycle. With `RD_LAT`=1 it is asserted the cycle after `bk_rstart`.
- `cfg_ctrl` reflects a write on the cycle after `bk_wstart`.
- `irq` rises 2 cycles after an enabled `irq_event` bit: 1 cycle for IRQ_STAT, 1 cycle for `irq`.
- A STATUS read returns `sts_in` as sampled 1 cycle before the `bk_rstart` edge.
- Writes are accepted in every cycle, including while a read is BUSY.
- Reset asserted mid-read aborts the read: no `bk_rdone` is produced, and all registers return to their reset values.

## Configuration
Macro: `AXILITE_REGBANK_WLOCK_EN`.
- Defined: adds a LOCK register at 0x018, RW bit0, reset 0; reads return {31'b0, lock}.
  - Once LOCK is 1, writes to CTRL and IRQ_EN are ignored, and writes to LOCK cannot clear it. Only reset clears LOCK.
  - IRQ_STAT W1C and SCRATCH remain writable while locked.
- Not defined: 0x018 is unmapped (reads 0, writes ignored), and CTRL and IRQ_EN are always writable.

## Test plan
- Reset, then read 0x014 with `RD_LAT`=2 → `bk_rdone` asserted 2 cycles after `bk_rstart`, `bk_rdata`=32'h4653_4943. `bk_rdata` is 0 in every other cycle.
- Write 0x010 data 32'hAABBCCDD, strb 4'b0101, starting from 0 → read returns 32'h00BB00DD.
- Pulse `irq_event`=8'h04 with IRQ_EN=8'h04 → `irq`=1 two cycles later.
  - Then write 0x008 data 8'h04 in the same cycle as another `irq_event` bit-2 pulse → IRQ_STAT bit 2 stays 1.
  - A subsequent clear write with no event → `irq`=0.
- Write CTRL=32'h1234 in the same cycle as `bk_rstart` to 0x000 (old value 0) → `bk_rdone` returns 0, and `cfg_ctrl`=32'h1234 the next cycle.
- Second `bk_rstart` issued while BUSY → exactly one `bk_rdone`.
  - Assert reset during BUSY → no `bk_rdone`, and all outputs are 0.
- With `AXILITE_REGBANK_WLOCK_EN` defined: write LOCK=1, then CTRL=32'hFFFF_FFFF → `cfg_ctrl` stays at its prior value. Write LOCK=0 → LOCK reads 1.
  - Without the macro: writing 0x018 has no effect, and reading 0x018 returns 0.
